// File: rtl/addsub_logic_pkg.sv
// Shared definitions for the 64-bit add/sub/logic execute slice.
// Holds the operation encoding and the default datapath width.
package addsub_logic_pkg;

  localparam int ADDSUB_WIDTH = 64;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage : addsub_logic_pkg

// File: rtl/addsub_core64.sv
// Combinational ripple add/sub core. Operand b is inverted when m is set
// and m doubles as the carry-in, so a single adder performs a+b and a-b.
module addsub_core64
  import addsub_logic_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff_s;

  assign b_eff_s = b ^ {WIDTH{m}};

  // Each stage keeps its own carry net so the chain is not one circular vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cin_s;
    logic cout_s;

    if (i == 0) begin : g_lsb
      assign cin_s = m;
    end else begin : g_chain
      assign cin_s = g_bit[i-1].cout_s;
    end

    assign sum[i] = a[i] ^ b_eff_s[i] ^ cin_s;
    assign cout_s = (a[i] & b_eff_s[i]) | (cin_s & (a[i] ^ b_eff_s[i]));
  end

  assign carry = g_bit[WIDTH-1].cout_s;
  assign ovf   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : addsub_core64

// File: rtl/addsub_logic_unit_64.sv
// Registered 64-bit ADD/SUB/AND/OR slice with one-cycle latency and full
// throughput. Outputs come straight from flops; no input-to-output comb path.
module addsub_logic_unit_64
  import addsub_logic_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  logic             m_s;
  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             ovf_s;
  logic [WIDTH-1:0] result_nxt_s;
  logic             cout_nxt_s;
  logic             ovf_nxt_s;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  assign m_s = (op == OP_SUB);

  addsub_core64 #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a),
    .b     (b),
    .m     (m_s),
    .sum   (sum_s),
    .carry (carry_s),
    .ovf   (ovf_s)
  );

  // Select next result and flags; logic ops force carry and overflow low.
  always_comb begin
    result_nxt_s = {WIDTH{1'b0}};
    cout_nxt_s   = 1'b0;
    ovf_nxt_s    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result_nxt_s = sum_s;
        cout_nxt_s   = carry_s;
        ovf_nxt_s    = ovf_s;
      end
      OP_AND: result_nxt_s = a & b;
      OP_OR:  result_nxt_s = a | b;
      default: begin
        result_nxt_s = {WIDTH{1'b0}};
        cout_nxt_s   = 1'b0;
        ovf_nxt_s    = 1'b0;
      end
    endcase
  end

  // Output registers: capture on in_valid, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        result_r <= result_nxt_s;
        cout_r   <= cout_nxt_s;
        ovf_r    <= ovf_nxt_s;
      end else begin
        result_r <= result_r;
        cout_r   <= cout_r;
        ovf_r    <= ovf_r;
      end
    end
  end

  assign result    = result_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;
  assign out_valid = out_valid_r;

endmodule : addsub_logic_unit_64

// File: tb/tb_addsub_logic_unit_64.sv
// Directed self-checking bench for addsub_logic_unit_64.
module tb_addsub_logic_unit_64;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic [63:0] result;
  logic        cout;
  logic        overflow;
  logic        out_valid;

  int n_assert;
  int n_fail;

  addsub_logic_unit_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [63:0] av, input logic [63:0] bv, input logic [1:0] ov);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    op       = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] r, input logic c, input logic o, input logic v);
    chk({tag, "_result"},   result,            r);
    chk({tag, "_cout"},     {63'd0, cout},     {63'd0, c});
    chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, o});
    chk({tag, "_valid"},    {63'd0, out_valid}, {63'd0, v});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 64'd0;
    b        = 64'd0;
    op       = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk_out("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 64'h10, 64'h20, 2'b00);
    chk_out("add_small", 64'h30, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00);
    chk_out("add_wrap", 64'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00);
    chk_out("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 64'h30, 64'h10, 2'b01);
    chk_out("sub_small", 64'h20, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h0, 64'h1, 2'b01);
    chk_out("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h8000_0000_0000_0000, 64'h1, 2'b01);
    chk_out("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    step(1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 2'b11);
    chk_out("or_alt", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 2'b10);
    chk_out("and_mask", 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b1);

    // Idle gap, then four back-to-back operations.
    step(1'b0, 64'h0, 64'h0, 2'b00);
    chk_out("idle_hold", 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h5, 64'h3, 2'b00);
    chk_out("b2b_add", 64'h8, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h5, 64'h3, 2'b01);
    chk_out("b2b_sub", 64'h2, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'hF0, 64'h3C, 2'b10);
    chk_out("b2b_and", 64'h30, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hF0, 64'h0F, 2'b11);
    chk_out("b2b_or", 64'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b0, 64'h1234, 64'h5678, 2'b00);
    chk_out("hold_or", 64'hFF, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while a valid result is presented.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00);
    chk_out("pre_reset", 64'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h8000_0000_0000_0000, 64'h1, 2'b01);
    chk_out("pre_reset2", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 64'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b1, 64'h1, 64'h1, 2'b00);
    chk_out("post_reset", 64'h2, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_addsub_logic_unit_64

// File: doc/addsub_logic_unit_64.md
Name: addsub_logic_unit_64

Overview:
Registered 64-bit arithmetic/logic slice providing ADD, SUB (two's-complement, M-controlled), bitwise AND and bitwise OR. Sits in the integer-execute path beside the shift/compare/XOR units; the ALU result mux selects its output. One operation accepted per cycle; result registered with one-cycle latency.

Parameters:
WIDTH, 64, operand/result width (all behaviour and tests at 64).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands/op valid this cycle.
a  input  WIDTH  operand A (rs1).
b  input  WIDTH  operand B (rs2/imm).
op  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
result  output  WIDTH  registered result.
cout  output  1  registered carry-out of the adder (0 for AND/OR).
overflow  output  1  registered signed overflow (0 for AND/OR).
out_valid  output  1  result/cout/overflow valid.

Behaviour:
- Reset (rst_n low, asynchronous, any time): result=0, cout=0, overflow=0, out_valid=0 immediately; held until rst_n high; first capture on first rising clk after release.
- Latency 1: when in_valid=1 at rising clk, outputs next cycle reflect that a/b/op; out_valid=1 for exactly that cycle unless next in_valid also 1 (back-to-back, full throughput, no stall).
- in_valid=0 at clk: out_valid<=0; result/cout/overflow hold previous values.
- ADD: {cout,result} = a + b, carry-in 0, mod 2^64 wrap (e.g. all-ones + 1 -> result 0, cout 1).
- SUB: result = a + ~b + 1 (M=1 inverts b, carry-in 1); cout = carry out of that sum (1 iff a >= b unsigned); 0 - 1 -> all-ones, cout 0.
- overflow (ADD/SUB): 1 iff a[63] and effective-b[63] equal and result[63] differs.
- AND: result = a & b; OR: result = a | b; cout=0, overflow=0.
- Adder: single shared adder, b XOR-ed with M=(op==01), carry-in=M; combinational path from inputs to register only; no combinational path input->output.
- No X propagation from op: all four encodings defined.

Decomposition:
- Shared package addsub_logic_pkg: op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11; WIDTH default constant.
- One sub-module natural: addsub_core64 — combinational add/sub (inputs a, b, m; outputs sum, carry, ovf), built from per-bit full-adder generate chain. Logic ops and output registers in the top.

Test Plan:
- Reset: assert rst_n=0 mid-operation with out_valid=1 -> result=0, cout=0, overflow=0, out_valid=0 without waiting for clk.
- ADD: a=0x10, b=0x20, op=00 -> next cycle result=0x30, cout=0, overflow=0; a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cout=1.
- SUB: a=0x30, b=0x10, op=01 -> result=0x20, cout=1; a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0; a=0x8000_0000_0000_0000, b=1 -> overflow=1.
- OR: a=0xAAAA_AAAA_AAAA_AAAA, b=0x5555_5555_5555_5555, op=11 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0.
- AND: a=0xFFFF_FFFF_FFFF_FFFF, b=0x0F0F_0F0F_0F0F_0F0F, op=10 -> result=0x0F0F_0F0F_0F0F_0F0F.
- Throughput/hold: ADD, SUB, AND, OR on four consecutive cycles with in_valid=1 -> four consecutive correct results, out_valid high four cycles; then in_valid=0 -> out_valid=0, result holds last OR value.
